// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment and anode
// patterns (all active-low) plus the blank/show state encoding.
package sseg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    // Indexed by digit select; entry 0 is the rightmost concatenation term.
    localparam logic [3:0][3:0] ANODE_PAT = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    // Segment order {g,f,e,d,c,b,a}; indexed by nibble value 0..F.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_PAT[nibble_i];
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame input
// capture and a blanking gap at every digit change to suppress ghosting.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [1:0]  select,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam scan_state_e   RESET_STATE = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    scan_state_e   state_q, state_d;
    logic [15:0]   cap_value_q, cap_value_d;
    logic [3:0]    cap_dp_q, cap_dp_d;
    logic [3:0]    cap_en_q, cap_en_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          wrap;
    logic          capture;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;

    assign wrap    = (cnt_q == CNT_MAX);
    assign capture = wrap && (sel_q == 2'd3);

    always_comb begin
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        sel_d       = wrap ? sel_q + 2'd1 : sel_q;
        cap_value_d = capture ? value    : cap_value_q;
        cap_dp_d    = capture ? dp_in    : cap_dp_q;
        cap_en_d    = capture ? digit_en : cap_en_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d == BLANK_END) state_d = ST_SHOW;
            ST_SHOW:  if (wrap && (BLANK_END != '0)) state_d = ST_BLANK;
            default:  state_d = RESET_STATE;
        endcase
    end

    // Outputs are computed from next-state values so that select, seg and
    // anode all change together on the slot-boundary edge.
    assign nibble = cap_value_d[{sel_d, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_dec)
    );

    always_comb begin
        anode_d      = ANODE_OFF;
        dp_d         = 1'b1;
        seg_d        = seg_dec;
        frame_done_d = capture;
        if (state_d == ST_SHOW) begin
            if (cap_en_d[sel_d]) anode_d = ANODE_PAT[sel_d];
            dp_d = ~cap_dp_d[sel_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            state_q      <= RESET_STATE;
            cap_value_q  <= '0;
            cap_dp_q     <= '0;
            cap_en_q     <= '0;
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            state_q      <= state_d;
            cap_value_q  <= cap_value_d;
            cap_dp_q     <= cap_dp_d;
            cap_en_q     <= cap_en_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign select     = sel_q;
    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two instances (blanking 2 and 0) checked every
// cycle against a timeline model fed by a queue of captured frames.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dpIn;
    logic [3:0]  digitEn;

    logic [1:0]  selB;
    logic [3:0]  anodeB;
    logic [6:0]  segB;
    logic        dpB;
    logic        frameDoneB;

    logic [1:0]  selZ;
    logic [3:0]  anodeZ;
    logic [6:0]  segZ;
    logic        dpZ;
    logic        frameDoneZ;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
    } frame_t;

    frame_t sbQueue[$];
    frame_t cur;
    int     cyc;
    int     testCount = 0;
    int     failCount = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dutBlank (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dpIn),
        .digit_en   (digitEn),
        .select     (selB),
        .anode      (anodeB),
        .seg        (segB),
        .dp         (dpB),
        .frame_done (frameDoneB)
    );

    sseg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(0)) dutNoBlank (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dpIn),
        .digit_en   (digitEn),
        .select     (selZ),
        .anode      (anodeZ),
        .seg        (segZ),
        .dp         (dpZ),
        .frame_done (frameDoneZ)
    );

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value   = v;
        dpIn    = d;
        digitEn = e;
    endtask

    // Expected outputs follow directly from the cycle count since reset
    // release and the frame most recently taken from the scoreboard.
    task automatic checkOutput(input string tag, input logic [1:0] selO, input logic [3:0] anO,
                               input logic [6:0] segO, input logic dpO, input logic fdO,
                               input int blankCycles);
        logic [1:0] s;
        logic       blank;
        logic [3:0] expAnode;
        logic [6:0] expSeg;
        logic       expDp;
        s        = 2'((cyc / 8) % 4);
        blank    = (cyc % 8) < blankCycles;
        expSeg   = segOf(cur.v[4*s +: 4]);
        expAnode = (!blank && cur.en[s]) ? ~(4'b0001 << s) : 4'b1111;
        expDp    = blank ? 1'b1 : ~cur.dp[s];
        checkEq({tag, ".select"}, 16'(selO), 16'(s));
        checkEq({tag, ".seg"}, 16'(segO), 16'(expSeg));
        checkEq({tag, ".anode"}, 16'(anO), 16'(expAnode));
        checkEq({tag, ".dp"}, 16'(dpO), 16'(expDp));
        checkEq({tag, ".frame_done"}, 16'(fdO), 16'((cyc % 32) == 0));
        checkEq({tag, ".oneAnode"}, 16'($countones(~anO) <= 1), 16'd1);
        checkEq({tag, ".ghost"}, 16'((anO == 4'b1111) || (segO === expSeg)), 16'd1);
    endtask

    task automatic checkReset(input string tag);
        checkEq({tag, ".B.select"}, 16'(selB), 16'd0);
        checkEq({tag, ".B.anode"}, 16'(anodeB), 16'hF);
        checkEq({tag, ".B.seg"}, 16'(segB), 16'h7F);
        checkEq({tag, ".B.dp"}, 16'(dpB), 16'd1);
        checkEq({tag, ".B.frame_done"}, 16'(frameDoneB), 16'd0);
        checkEq({tag, ".Z.select"}, 16'(selZ), 16'd0);
        checkEq({tag, ".Z.anode"}, 16'(anodeZ), 16'hF);
        checkEq({tag, ".Z.seg"}, 16'(segZ), 16'h7F);
        checkEq({tag, ".Z.dp"}, 16'(dpZ), 16'd1);
        checkEq({tag, ".Z.frame_done"}, 16'(frameDoneZ), 16'd0);
    endtask

    // The inputs present just before a capture edge are pushed; the frame is
    // popped when the display starts showing it.
    task automatic tick();
        if (((cyc + 1) % 32) == 0) sbQueue.push_back({value, dpIn, digitEn});
        @(posedge clk);
        #1;
        cyc++;
        if ((cyc % 32) == 0) begin
            checkEq("scoreboard.depth", 16'(sbQueue.size()), 16'd1);
            if (sbQueue.size() != 0) cur = sbQueue.pop_front();
        end
        checkOutput("blank2", selB, anodeB, segB, dpB, frameDoneB, 2);
        checkOutput("blank0", selZ, anodeZ, segZ, dpZ, frameDoneZ, 0);
    endtask

    task automatic restartModel();
        cyc = 0;
        cur = '0;
        sbQueue.delete();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(16'h1234, 4'b0000, 4'b1111);
        restartModel();
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        reset = 1'b0;
        checkReset("released");

        // First frame dark, second frame shows 1234.
        repeat (64) tick();

        applyStimulus(16'hABCD, 4'b0100, 4'b0101);
        repeat (64) tick();

        // Inputs churn mid-frame; only capture-edge values may be displayed.
        applyStimulus(16'h0000, 4'b0000, 4'b1111);
        for (int i = 0; i < 96; i++) begin
            if ((i % 3) == 0) applyStimulus(16'($urandom), 4'($urandom), 4'b1111);
            tick();
        end

        applyStimulus(16'h5A6F, 4'b1001, 4'b1111);
        for (int i = 0; i < 40 && (cyc % 32) != 20; i++) tick();
        checkEq("reachSlot2Show", 16'(cyc % 32), 16'd20);
        #2;
        reset = 1'b1;
        #1;
        checkReset("asyncReset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        restartModel();
        checkReset("restart");

        for (int f = 0; f < 10; f++) begin
            applyStimulus(16'($urandom), 4'($urandom), 4'b1111);
            repeat (32) tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

- Time-multiplexed driver for the 4-digit common-anode seven-segment display.
- Latches a 16-bit hex value, plus per-digit decimal-point and enable masks, once per frame.
- Steps a 2-bit digit select through 0..3 and produces active-low anode, segment and dp outputs, with a blanking gap at every digit change to prevent ghosting.
- It is the scanning/driving end of the anode-select interface; its anode output follows the same select-to-anode encoding the display path already uses.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- BLANK_CYCLES, default 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 disables blanking.
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  16  hex value to display; digit n = value[4n+3:4n].
- dp_in  input  4  decimal point request per digit, active-high.
- digit_en  input  4  per-digit enable, active-high; a disabled digit stays dark.
- select  output  2  current digit index.
- anode  output  4  active-low digit enables.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- frame_done  output  1  one-cycle pulse when a new frame is captured.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps. select increments on each wrap, 3→0.
- States:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW otherwise.
  - BLANK→SHOW when cnt reaches BLANK_CYCLES.
  - SHOW→BLANK on wrap.
  - With BLANK_CYCLES = 0, the block is always in SHOW.
- BLANK outputs: anode = 1111, dp = 1; seg already shows the new digit's pattern.
- SHOW anode:
  - select 00→1110, 01→1101, 10→1011, 11→0111.
  - Forced to 1111 if the captured digit_en[select] = 0.
- SHOW dp = ~captured dp_in[select].
- seg is the hex-to-7seg decode of the captured nibble for the current select:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000.
  - 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Frame capture:
  - value, dp_in and digit_en are registered at the edge where select wraps 3→0.
  - frame_done is high for exactly that following cycle.
  - Input changes mid-frame never appear until the next frame, so there is no tearing.
- Reset (any time, including mid-slot):
  - Counters and state: cnt = 0, select = 00, state BLANK (SHOW if BLANK_CYCLES = 0).
  - Outputs: anode = 1111, seg = 1111111, dp = 1, frame_done = 0.
  - Captured registers: all zero.
  - The first frame after reset is therefore fully dark (digit_en captured as 0000).

## Timing
- All outputs are registered. select, seg, anode and dp change only on clock edges, never glitch combinationally.
- At each slot boundary, select, seg and anode (to 1111) update on the same edge.
- anode becomes active BLANK_CYCLES cycles after the boundary.
- Slot length is exactly REFRESH_DIV cycles. Frame length is 4·REFRESH_DIV cycles.
- First frame_done after reset release: at the edge ending cycle 4·REFRESH_DIV.
- Capture-to-display latency: the captured digit 0 is visible after BLANK_CYCLES cycles; digit n after n·REFRESH_DIV + BLANK_CYCLES.
- Input values held only between captures are ignored. No handshake; inputs are sampled, not acknowledged.

## Structure
- Shared package sseg_pkg holds:
  - the 16 segment patterns;
  - the 4 anode patterns and the all-off constant ANODE_OFF = 4'b1111;
  - the BLANK/SHOW state encoding.
- One combinational sub-module, hex_to_sseg (4-bit nibble → 7-bit active-low segments), instantiated once on the selected captured nibble.
- The counter, FSM, capture registers and output registers live in sseg_scan_driver (≈150–250 lines).

## Test plan
All scenarios use REFRESH_DIV = 8 and BLANK_CYCLES = 2.
- Reset, release, value = 16'h1234, digit_en = 1111, dp_in = 0000:
  - Frame 1 is fully dark.
  - frame_done pulses at cycle 32.
  - Frame 2 shows slot 0: anode 1111 for 2 cycles, then 1110 with seg 0011001 ("4") for 6 cycles.
  - Then slots 1/2/3 show 3/2/1 on anodes 1101/1011/0111.
- value = 16'hABCD with digit_en = 0101, dp_in = 0100:
  - Only anodes 1110 and 1011 ever go low.
  - dp = 0 only during slot 2 SHOW cycles.
- Change value every 3 cycles mid-frame: the displayed digits equal the value sampled at the preceding frame_done, with no mixing within a frame.
- Assert reset during slot 2 SHOW: the outputs go to reset values immediately (asynchronously), and after release the sequence restarts at select = 00.
- Ghost check over 10 frames:
  - anode is never low in any cycle where seg differs from the decode of the current select.
  - At most one anode bit is ever low.
- BLANK_CYCLES = 0:
  - anode is active on every cycle of enabled slots.
  - select wraps 3→0 every 32 cycles.
